// File: rtl/mem_sequencer_pkg.sv
// Shared encodings for the memory sequencer: operations, error codes, FSM states.
package cpu_data;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_PUSH  = 2'd2,
      OP_POP   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_OVERFLOW  = 2'd1,
      ERR_UNDERFLOW = 2'd2,
      ERR_TIMEOUT   = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ERR
   } state_e;

   function automatic logic op_is_read(input op_e o);
      return (o == OP_READ) || (o == OP_POP);
   endfunction

endpackage

// File: rtl/mem_sequencer_wait_counter.sv
// Wait-state counter: counts cycles while clear is low, expired on the MAX_WAIT-th cycle.
module wait_counter #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (!expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_sequencer.sv
// Memory/stack bus sequencer for READ, WRITE, PUSH, POP.
// Optional ACCESS timeout enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_sequencer
   import cpu_data::*;
#(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] SP_TOP   = 'h07FF,
   parameter logic [ADDR_W-1:0] SP_LIMIT = 'h0600,
   parameter int unsigned       MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] address_bus,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   output logic              r,
   output logic              w,
   input  logic              rdy
);

`ifdef MEM_SEQ_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   state_e            state, state_nxt;
   err_e              err_nxt;
   op_e               op_q;
   op_e               op_in;
   logic [ADDR_W-1:0] addr_sel;
   logic              wait_expired;
   logic              timeout;

   wait_counter #(
      .MAX_WAIT(MAX_WAIT)
   ) u_wait_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != ST_ACCESS),
      .expired(wait_expired)
   );

   assign timeout = TIMEOUT_EN && wait_expired;
   assign op_in   = op_e'(op);

   // Bus address is loaded at acceptance so it is already stable during SETUP.
   always_comb begin
      addr_sel = addr_in;
      case (op_in)
         OP_PUSH: addr_sel = sp;
         OP_POP:  addr_sel = sp + 1'b1;
         default: addr_sel = addr_in;
      endcase
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = ERR_NONE;
      case (state)
         ST_IDLE: begin
            if (req) state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            if (op_q == OP_PUSH && sp < SP_LIMIT) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_OVERFLOW;
            end else if (op_q == OP_POP && sp == SP_TOP) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_UNDERFLOW;
            end else begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (rdy) begin
               state_nxt = ST_DONE;
            end else if (timeout) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      r    = 1'b0;
      w    = 1'b0;
      done = 1'b0;
      err  = 1'b0;
      case (state)
         ST_ACCESS: begin
            r = op_is_read(op_q);
            w = !op_is_read(op_q);
         end
         ST_DONE: done = 1'b1;
         ST_ERR:  err  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_q        <= OP_READ;
         sp          <= SP_TOP;
         address_bus <= '0;
         data_out    <= '0;
         rdata       <= '0;
         err_code    <= '0;
      end else begin
         state    <= state_nxt;
         err_code <= err_nxt;
         if (state == ST_IDLE && req) begin
            op_q        <= op_in;
            address_bus <= addr_sel;
            data_out    <= wdata;
         end
         if (state == ST_ACCESS && rdy) begin
            if (op_is_read(op_q)) rdata <= data_in;
            if (op_q == OP_PUSH) sp <= sp - 1'b1;
            if (op_q == OP_POP)  sp <= sp + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer; covers the timeout path when MEM_SEQ_TIMEOUT_EN is defined.
module tb_mem_sequencer;
   import cpu_data::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [1:0]  op;
   logic [15:0] addr_in;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] sp;
   logic [15:0] address_bus;
   logic [15:0] data_out;
   logic [15:0] data_in;
   logic        r;
   logic        w;
   logic        rdy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        is_err;
      logic [1:0]  code;
      logic        chk_rd;
      logic [15:0] rd;
      logic [15:0] sp;
   } exp_t;

   exp_t sb[$];

   mem_sequencer #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .SP_TOP  (16'h07FF),
      .SP_LIMIT(16'h0600),
      .MAX_WAIT(15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .op         (op),
      .addr_in    (addr_in),
      .wdata      (wdata),
      .rdata      (rdata),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .sp         (sp),
      .address_bus(address_bus),
      .data_out   (data_out),
      .data_in    (data_in),
      .r          (r),
      .w          (w),
      .rdy        (rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: pops one expectation per done/err pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (r && w) begin
            n_checks++;
            n_fail++;
            $display("FAIL rw_exclusive: got r=1 w=1 expected at most one");
         end
         if (done || err) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got done=%b err=%b expected none", done, err);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("resp_done", 32'(done), 32'(!e.is_err));
               check("resp_err", 32'(err), 32'(e.is_err));
               check("err_code", 32'(err_code), e.is_err ? 32'(e.code) : 32'd0);
               if (e.chk_rd) check("rdata", 32'(rdata), 32'(e.rd));
               check("sp_after", 32'(sp), 32'(e.sp));
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] din, input int nwait, input logic exp_err,
                         input logic [1:0] exp_code, input logic [15:0] exp_rd,
                         input logic [15:0] exp_sp, input logic [15:0] exp_addr,
                         input int exp_k, input int exp_strobes);
      exp_t e;
      int   k;
      int   s;
      int   addr_bad;
      int   data_bad;
      int   kind_bad;
      logic seen;
      logic is_rd;
      is_rd    = (o == 2'd0) || (o == 2'd3);
      e.is_err = exp_err;
      e.code   = exp_code;
      e.chk_rd = is_rd && !exp_err;
      e.rd     = exp_rd;
      e.sp     = exp_sp;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b1; op = o; addr_in = a; wdata = wd; data_in = din; rdy = 1'b0;
      k = 0; s = 0; addr_bad = 0; data_bad = 0; kind_bad = 0; seen = 1'b0;
      while (!seen && k < 60) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            op = o ^ 2'b01; wdata = ~wd; addr_in = ~a;
         end
         if (r || w) begin
            s++;
            if (address_bus !== exp_addr) addr_bad++;
            if (w && data_out !== wd) data_bad++;
            if (r !== is_rd) kind_bad++;
            if (s > nwait) rdy = 1'b1;
         end
         if (done || err) begin
            seen = 1'b1; req = 1'b0; rdy = 1'b0;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL op_timeout: got no done/err after %0d cycles expected response", k);
         req = 1'b0; rdy = 1'b0;
      end
      check("latency", 32'(k), 32'(exp_k));
      check("strobe_cycles", 32'(s), 32'(exp_strobes));
      if (exp_strobes > 0) begin
         check("addr_stable", 32'(addr_bad), 32'd0);
         check("write_data", 32'(data_bad), 32'd0);
         check("strobe_kind", 32'(kind_bad), 32'd0);
      end
   endtask

   initial begin
      int guard;
      reset = 1'b1; req = 1'b0; op = 2'd0; addr_in = '0; wdata = '0; data_in = '0; rdy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sp", 32'(sp), 32'h07FF);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_rw", 32'({r, w}), 32'd0);
      check("rst_addr", 32'(address_bus), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      reset = 1'b0;

      run_op(2'd2, 16'h0000, 16'h1234, 16'h0000, 0, 1'b0, 2'd0, 16'h0000, 16'h07FE, 16'h07FF, 3, 1);
      run_op(2'd3, 16'h0000, 16'h0000, 16'h1234, 0, 1'b0, 2'd0, 16'h1234, 16'h07FF, 16'h07FF, 3, 1);
      run_op(2'd3, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 2'd2, 16'h0000, 16'h07FF, 16'h0000, 2, 0);
      run_op(2'd0, 16'h0100, 16'h0000, 16'hABCD, 4, 1'b0, 2'd0, 16'hABCD, 16'h07FF, 16'h0100, 7, 5);
      run_op(2'd1, 16'h0200, 16'h5A5A, 16'h0000, 1, 1'b0, 2'd0, 16'h0000, 16'h07FF, 16'h0200, 4, 2);

      for (int i = 0; i < 512; i++) begin
         run_op(2'd2, 16'h0000, 16'(i) ^ 16'hC3C3, 16'h0000, i % 3, 1'b0, 2'd0, 16'h0000,
                16'(16'h07FF - i - 1), 16'(16'h07FF - i), 3 + (i % 3), 1 + (i % 3));
      end
      run_op(2'd2, 16'h0000, 16'h9999, 16'h0000, 0, 1'b1, 2'd1, 16'h0000, 16'h05FF, 16'h0000, 2, 0);
      run_op(2'd3, 16'h0000, 16'h0000, 16'hBEEF, 0, 1'b0, 2'd0, 16'hBEEF, 16'h0600, 16'h0600, 3, 1);

      @(negedge clk);
      req = 1'b1; op = 2'd2; wdata = 16'h7777; rdy = 1'b0;
      guard = 0;
      while (!w && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("abort_reached_access", 32'(w), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; req = 1'b0;
      check("abort_sp", 32'(sp), 32'h07FF);
      check("abort_rw", 32'({r, w}), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 32'({done, err}), 32'd0);
      end

      run_op(2'd2, 16'h0000, 16'h4242, 16'h0000, 0, 1'b0, 2'd0, 16'h0000, 16'h07FE, 16'h07FF, 3, 1);
`ifdef MEM_SEQ_TIMEOUT_EN
      run_op(2'd1, 16'h0300, 16'h1111, 16'h0000, 100, 1'b1, 2'd3, 16'h0000, 16'h07FE, 16'h0300, 17, 15);
`else
      run_op(2'd1, 16'h0300, 16'h1111, 16'h0000, 20, 1'b0, 2'd0, 16'h0000, 16'h07FE, 16'h0300, 23, 21);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
